// File: rtl/int_src_ctrl_pkg.sv
// Shared constants for the interrupt source controller: FSM encoding,
// CSR map and CSR port widths.
package int_src_ctrl_pkg;

  localparam int CSR_ADDR_W = 2;
  localparam int CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [CSR_ADDR_W-1:0] ADDR_PENDING = 2'd0;
  localparam logic [CSR_ADDR_W-1:0] ADDR_MASK    = 2'd1;
  localparam logic [CSR_ADDR_W-1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [CSR_ADDR_W-1:0] ADDR_STATUS  = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/int_src_ctrl_if.sv
// Software register port of the interrupt source controller.
// Master is the CPU/bus side, slave is the controller.
interface int_src_ctrl_if;
  import int_src_ctrl_pkg::*;

  logic                  csr_we;
  logic [CSR_ADDR_W-1:0] csr_addr;
  logic [CSR_DATA_W-1:0] csr_wdata;
  logic [CSR_DATA_W-1:0] csr_rdata;

  modport master (output csr_we, csr_addr, csr_wdata, input  csr_rdata);
  modport slave  (input  csr_we, csr_addr, csr_wdata, output csr_rdata);

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: id is the index of the lowest set
// bit of eligible, any flags that at least one bit is set.
module int_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    eligible,
  output logic            any,
  output logic [ID_W-1:0] id
);

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    any = |eligible;
    id  = '0;
    // Scan downward so the last hit, the lowest index, is the one kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_src_ctrl.sv
// Interrupt source controller: latches rising device requests as pending,
// masks and prioritises them, pulses INT once per cause and waits for eret.
module int_src_ctrl
  import int_src_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             eret,
  output logic             INT,
  output logic             busy,
  int_src_ctrl_if.slave    csr
);

  state_t            state;
  logic [N_SRC-1:0]  irq_d;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  w1c;
  logic [N_SRC-1:0]  grant_clr;
  logic              win_any;
  logic [ID_W-1:0]   win_id;
  logic              grant;
  logic              cause_valid;
  logic [ID_W-1:0]   cause_id;
  logic              pend_wr;
  logic              mask_wr;
  logic              unused_wdata;

  assign rise      = irq_src & ~irq_d;
  assign eligible  = pending & mask;
  assign grant     = (state == IDLE) && win_any;
  assign pend_wr   = csr.csr_we && (csr.csr_addr == ADDR_PENDING);
  assign mask_wr   = csr.csr_we && (csr.csr_addr == ADDR_MASK);
  assign w1c       = pend_wr ? csr.csr_wdata[N_SRC-1:0] : '0;
  assign grant_clr = grant ? (N_SRC'(1) << win_id) : '0;

  // Upper write-data bits have no destination for narrow configurations.
  assign unused_wdata = ^csr.csr_wdata;

  int_prio_enc #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .eligible (eligible),
    .any      (win_any),
    .id       (win_id)
  );

  // Arbiter sees pre-write pending/mask; software clear and grant clear
  // merge, and a fresh rise on the same cycle always keeps its bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      irq_d   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      irq_d   <= irq_src;
      pending <= (pending & ~(w1c | grant_clr)) | rise;
      if (mask_wr) mask <= csr.csr_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      INT         <= 1'b0;
      busy        <= 1'b0;
      cause_valid <= 1'b0;
      cause_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_any) begin
            cause_id    <= win_id;
            cause_valid <= 1'b1;
            INT         <= 1'b1;
            busy        <= 1'b1;
            state       <= ASSERT;
          end
        end
        ASSERT: begin
          INT   <= 1'b0;
          state <= SERVICE;
        end
        SERVICE: begin
          if (eret) begin
            cause_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          INT   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    csr.csr_rdata = '0;
    unique case (csr.csr_addr)
      ADDR_PENDING: csr.csr_rdata = CSR_DATA_W'(pending);
      ADDR_MASK:    csr.csr_rdata = CSR_DATA_W'(mask);
      ADDR_CAUSE: begin
        csr.csr_rdata[CAUSE_VALID_BIT] = cause_valid;
        csr.csr_rdata[ID_W-1:0]        = cause_id;
      end
      ADDR_STATUS:  csr.csr_rdata[1:0] = state;
      default:      csr.csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_src_ctrl.sv
// Bench for int_src_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_int_src_ctrl;
  import int_src_ctrl_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         eret;
  logic         int_pulse;
  logic         busy;

  int_src_ctrl_if csr ();

  int_src_ctrl #(
    .N_SRC (N),
    .ID_W  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .eret    (eret),
    .INT     (int_pulse),
    .busy    (busy),
    .csr     (csr)
  );

  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  string reg_name [4] = '{"PENDING", "MASK", "CAUSE", "STATUS"};

  // Behavioural model: phase 0 = waiting for work, 1 = pulse just sent,
  // 2 = CPU servicing until eret.
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic         m_int, m_busy, m_cv;
  logic [2:0]   m_cid;
  int           m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0:       return {24'b0, m_pend};
      1:       return {24'b0, m_mask};
      2:       return {m_cv, 28'b0, m_cid};
      default: return 32'(m_phase);
    endcase
  endfunction

  task automatic model_step();
    logic [N-1:0] rise, clr, elig, low, new_mask;
    if (reset) begin
      m_pend = '0; m_mask = '1; m_prev = '0;
      m_int = 0; m_busy = 0; m_cv = 0; m_cid = '0; m_phase = 0;
      return;
    end
    rise     = irq_src & ~m_prev;
    clr      = (csr.csr_we && csr.csr_addr == 2'd0) ? csr.csr_wdata[N-1:0] : '0;
    new_mask = (csr.csr_we && csr.csr_addr == 2'd1) ? csr.csr_wdata[N-1:0] : m_mask;
    if (m_phase == 0) begin
      elig = m_pend & m_mask;
      if (elig != 0) begin
        low     = elig & (~elig + 8'd1);
        m_cid   = 3'($clog2(low));
        clr     = clr | low;
        m_cv    = 1; m_int = 1; m_busy = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_int = 0; m_phase = 2;
    end else if (eret) begin
      m_cv = 0; m_busy = 0; m_phase = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_mask = new_mask;
    m_prev = irq_src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("INT", 32'(int_pulse), 32'(m_int));
    check("busy", 32'(busy), 32'(m_busy));
    for (int a = 0; a < 4; a++) begin
      csr.csr_addr = 2'(a);
      #1;
      check(reg_name[a], csr.csr_rdata, exp_reg(a));
    end
    eret       = 1'b0;
    csr.csr_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    csr.csr_addr = a;
    #1;
    check(tag, csr.csr_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    csr.csr_we    = 1'b1;
    csr.csr_addr  = a;
    csr.csr_wdata = d;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; eret = 1'b0;
    csr.csr_we = 1'b0; csr.csr_addr = '0; csr.csr_wdata = '0;
    tick();
    check("reset_INT", 32'(int_pulse), 32'd0);
    rd_check("reset_MASK", ADDR_MASK, 32'h0000_00FF);
    reset = 1'b0;

    // Single source: pending, one-cycle pulse, cause.
    irq_src = 8'h08; tick();
    rd_check("s1_pending", ADDR_PENDING, 32'h08);
    tick();
    check("s1_INT_hi", 32'(int_pulse), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    rd_check("s1_cause", ADDR_CAUSE, 32'h8000_0003);
    tick();
    check("s1_INT_lo", 32'(int_pulse), 32'd0);
    eret = 1'b1; tick();
    irq_src = '0; tick();

    // Two simultaneous sources: lowest index first, the other after eret.
    irq_src = 8'h24; tick(); tick();
    rd_check("s2_cause2", ADDR_CAUSE, 32'h8000_0002);
    rd_check("s2_pending", ADDR_PENDING, 32'h20);
    tick();
    eret = 1'b1; tick();
    check("s2_gap", 32'(int_pulse), 32'd0);
    tick();
    check("s2_INT2", 32'(int_pulse), 32'd1);
    rd_check("s2_cause5", ADDR_CAUSE, 32'h8000_0005);
    tick();
    eret = 1'b1; tick();
    irq_src = '0; tick();

    // Masked source stays pending and fires once unmasked.
    wr(ADDR_MASK, 32'hFB); tick();
    irq_src = 8'h04; tick(); tick(); tick();
    check("s3_no_int", 32'(int_pulse), 32'd0);
    rd_check("s3_pending", ADDR_PENDING, 32'h04);
    wr(ADDR_MASK, 32'hFF); tick(); tick();
    check("s3_INT", 32'(int_pulse), 32'd1);
    rd_check("s3_cause", ADDR_CAUSE, 32'h8000_0002);
    tick();
    eret = 1'b1; tick();
    irq_src = '0; tick();

    // Repeated rises during service collapse into one pending bit.
    irq_src = 8'h40; tick(); tick(); tick();
    irq_src = 8'h42; tick(); irq_src = 8'h40; tick();
    irq_src = 8'h42; tick(); irq_src = 8'h40; tick();
    irq_src = 8'h42; tick();
    rd_check("s4_pending", ADDR_PENDING, 32'h02);
    eret = 1'b1; tick(); tick();
    rd_check("s4_cause", ADDR_CAUSE, 32'h8000_0001);
    tick();
    eret = 1'b1; tick(); tick();
    check("s4_one_int", 32'(int_pulse), 32'd0);
    irq_src = '0; tick();

    // Rise beats a same-cycle write-1-to-clear; a later clear removes it.
    wr(ADDR_MASK, 32'hEF); tick();
    irq_src = 8'h10; wr(ADDR_PENDING, 32'h10); tick();
    rd_check("s5_rise_wins", ADDR_PENDING, 32'h10);
    wr(ADDR_PENDING, 32'h10); tick();
    rd_check("s5_cleared", ADDR_PENDING, 32'h00);
    wr(ADDR_MASK, 32'hFF); tick(); tick();
    check("s5_no_int", 32'(int_pulse), 32'd0);
    irq_src = '0; tick();

    // Reset in the middle of service, then a stray eret in IDLE.
    wr(ADDR_MASK, 32'h0F); tick();
    irq_src = 8'h81; tick(); tick(); tick();
    rd_check("s6_service", ADDR_STATUS, 32'd2);
    reset = 1'b1; irq_src = '0; tick();
    rd_check("s6_status", ADDR_STATUS, 32'd0);
    rd_check("s6_cause", ADDR_CAUSE, 32'd0);
    rd_check("s6_pending", ADDR_PENDING, 32'd0);
    rd_check("s6_mask", ADDR_MASK, 32'hFF);
    check("s6_INT", 32'(int_pulse), 32'd0);
    reset = 1'b0; eret = 1'b1; tick();
    rd_check("s6_eret_idle", ADDR_STATUS, 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] d;
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0)
        irq_src = irq_src ^ N'($urandom_range(0, 255) & $urandom_range(0, 255));
      eret = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        d = $urandom();
        if ($urandom_range(0, 1) == 0) d = d | $urandom();
        wr(2'($urandom_range(0, 3)), d);
      end
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_src_ctrl.md
Name: int_src_ctrl

Overview:
- Interrupt source controller on the device side of the CPU interrupt line. It collects up to N device interrupt requests, latches them as pending, and applies a software mask and fixed priority.
- It drives a one-cycle INT pulse into the CPU interrupt logic, holds the serviced cause until the CPU returns with eret, then arms the next request.
- Software reads and clears state through a small register port.

Parameters:
- N_SRC, 8, number of device interrupt sources (1..32)
- ID_W, 3, width of the source ID; must equal clog2(N_SRC), minimum 1

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- irq_src  input  N_SRC  device request levels; the controller detects rising edges
- eret  input  1  CPU return-from-interrupt strobe; one cycle high
- INT  output  1  interrupt request pulse to the CPU; registered
- csr_we  input  1  register write strobe
- csr_addr  input  2  register select
- csr_wdata  input  32  register write data
- csr_rdata  output  32  register read data; combinational from csr_addr
- busy  output  1  high while a cause is in service (states ASSERT and SERVICE)

Behaviour:
- Reset (synchronous): INT=0, busy=0, pending=0, mask=all ones, cause_valid=0, cause_id=0, irq_d=0, state=IDLE.
- Edge detect: irq_d <= irq_src every cycle. rise = irq_src & ~irq_d.
  - Pending bit i is set on rise[i].
  - Level-held sources do not re-trigger.
- Registers (csr_addr):
  - 0 PENDING: read gives pending, zero-extended. Write is write-1-to-clear. A rise on the same bit in the same cycle wins, so the bit stays set.
  - 1 MASK: read/write, bits [N_SRC-1:0]; 1 = enabled. Upper bits read 0 and ignore writes.
  - 2 CAUSE: read-only. Bit 31 = cause_valid; bits [ID_W-1:0] = cause_id; other bits 0. Writes ignored.
  - 3 STATUS: read-only. Bits [1:0] = state encoding (IDLE=0, ASSERT=1, SERVICE=2); other bits 0.
- Arbitration: eligible = pending & mask. The lowest index has highest priority. The arbiter is combinational and evaluated only in IDLE.
- State machine:
  - IDLE: if eligible != 0, then cause_id <= winner, cause_valid <= 1, clear pending[winner], INT <= 1, state <= ASSERT. Else hold.
  - ASSERT: INT <= 0, state <= SERVICE. INT is high for exactly one cycle.
  - SERVICE: hold cause. On eret: cause_valid <= 0, state <= IDLE.
  - eret in IDLE or ASSERT is ignored.
- Latency:
  - A rise sampled at edge E0 sets pending.
  - With that source winning, INT is high from E1 to E2.
  - After eret at edge Ek, the earliest next INT is high from Ek+1 to Ek+2. This guarantees a low INT gap of at least one cycle, so every pulse is a fresh posedge to the CPU.
- Other boundary rules:
  - Clearing pending or mask while in ASSERT or SERVICE does not affect the in-service cause.
  - A pending bit that is masked stays pending and fires when unmasked, if the controller is in IDLE.
  - New rises during SERVICE accumulate in pending; multiple rises on the same bit collapse into one.
  - CSR writes and arbitration in the same IDLE cycle: the arbiter uses pre-write pending/mask values. The write-1-to-clear of the winner's bit and the arbiter's own clear combine (both clear).
  - reset asserted mid-service: return to reset values next edge, INT=0 immediately registered.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/ASSERT/SERVICE
  - CSR address constants ADDR_PENDING=0, ADDR_MASK=1, ADDR_CAUSE=2, ADDR_STATUS=3
  - CAUSE_VALID_BIT=31
- One sub-module: int_prio_enc, a parameterised lowest-index priority encoder. Inputs: eligible vector. Outputs: any, id.

Test Plan:
- Reset then rise irq_src[3] → pending=0x08 after one edge; INT high exactly one cycle on the next edge; CAUSE reads 0x80000003; busy=1.
- irq_src[5] and irq_src[2] rise together → cause_id=2, PENDING reads 0x20. After eret, INT pulses again with cause_id=5, with at least one INT-low cycle between pulses.
- MASK=0xFB, rise irq_src[2] → no INT, PENDING=0x04. Write MASK=0xFF → INT within two cycles, cause_id=2.
- In SERVICE, raise irq_src[1] three times → PENDING=0x02 (single bit). eret without an intervening pulse during SERVICE → exactly one more INT.
- Write PENDING=0x10 in the same cycle as a rise on bit 4 → bit 4 stays set. Write 0x10 on a later cycle → PENDING bit 4 cleared, no INT.
- Assert reset during SERVICE → next cycle state=IDLE, CAUSE=0, PENDING=0, MASK=0xFF, INT=0. eret in IDLE → no effect.
